// File: rtl/key_conditioner_if.sv
// Key signal bundle between the board buttons and the conditioner.
// The conditioner takes the slave view; the button source and consumers take the master view.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_repeat;

    modport master (
        output key_n,
        input  key_level, key_press, key_release, key_repeat
    );

    modport slave (
        input  key_n,
        output key_level, key_press, key_release, key_repeat
    );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key synchroniser, debouncer, press/release strobes
// and typematic auto-repeat. The top replicates one identical lane per key.
module key_conditioner_lane #(
    parameter int CNT_W           = 24,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, RATE} rpt_state_e;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] rcnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             repeat_q;
    rpt_state_e       state_q;
    logic             raw_s;
    logic             accept_s;

    assign raw_s    = ~sync_q[1];
    // Terminal debounce count while raw differs: the level flips on this edge.
    assign accept_s = (raw_s != level_q) && (dcnt_q == DB_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_n_i};
            press_q   <= accept_s & raw_s;
            release_q <= accept_s & ~raw_s;
            if (raw_s == level_q) begin
                dcnt_q <= '0;
            end else if (accept_s) begin
                level_q <= raw_s;
                dcnt_q  <= '0;
            end else begin
                dcnt_q <= dcnt_q + CNT_W'(1);
            end
        end
    end

    // Outside IDLE the level is 1, so any accept there is a release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rcnt_q   <= '0;
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rcnt_q <= '0;
                    if (accept_s && raw_s) begin
                        repeat_q <= 1'b1;
                        state_q  <= DELAY;
                    end
                end
                DELAY: begin
                    if (accept_s) begin
                        state_q <= IDLE;
                        rcnt_q  <= '0;
                    end else if (rcnt_q == RD_LAST) begin
                        repeat_q <= 1'b1;
                        rcnt_q   <= '0;
                        state_q  <= RATE;
                    end else begin
                        rcnt_q <= rcnt_q + CNT_W'(1);
                    end
                end
                RATE: begin
                    if (accept_s) begin
                        state_q <= IDLE;
                        rcnt_q  <= '0;
                    end else if (rcnt_q == RR_LAST) begin
                        repeat_q <= 1'b1;
                        rcnt_q   <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rcnt_q  <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;
endmodule

module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int CNT_W           = 24,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic         clk,
    input  logic         reset_n,
    key_conditioner_if.slave kif
);
    logic [NUM_KEYS-1:0] lvl_w;
    logic [NUM_KEYS-1:0] prs_w;
    logic [NUM_KEYS-1:0] rel_w;
    logic [NUM_KEYS-1:0] rpt_w;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_conditioner_lane #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .key_n_i  (kif.key_n[g]),
            .level_o  (lvl_w[g]),
            .press_o  (prs_w[g]),
            .release_o(rel_w[g]),
            .repeat_o (rpt_w[g])
        );
    end

    assign kif.key_level   = lvl_w;
    assign kif.key_press   = prs_w;
    assign kif.key_release = rel_w;
    assign kif.key_repeat  = rpt_w;
endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner against a window-based
// behavioural model (level flips when the last D synchronised samples all disagree).
module tb_key_conditioner;
    localparam int NK = 2;
    localparam int CW = 8;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();

    key_conditioner #(
        .NUM_KEYS(NK), .CNT_W(CW), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .kif    (kif)
    );

    always #5 clk = ~clk;

    // Model: per key, raw key_n samples newest first; entry i was sampled i edges ago.
    logic          samp [NK][D+2];
    logic [NK-1:0] m_lvl, m_prs, m_rel, m_rpt;
    int            pt [NK];
    int            cyc = 0;

    task automatic check(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit rep_due(input int d);
        return (d == 0) || (d == RD) || (d > RD && ((d - RD) % RR) == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            for (int i = 0; i < D + 2; i++) samp[k][i] = 1'b1;
            pt[k] = 0;
        end
        m_lvl = '0; m_prs = '0; m_rel = '0; m_rpt = '0;
    endtask

    task automatic model_step(input logic [NK-1:0] kn);
        bit flip;
        cyc++;
        for (int k = 0; k < NK; k++) begin
            for (int i = D + 1; i > 0; i--) samp[k][i] = samp[k][i-1];
            samp[k][0] = kn[k];
            // Samples 2..D+1 edges old are what the debouncer has seen for D cycles.
            flip = 1'b1;
            for (int i = 2; i <= D + 1; i++)
                if (!samp[k][i] == m_lvl[k]) flip = 1'b0;
            m_prs[k] = 1'b0;
            m_rel[k] = 1'b0;
            if (flip) begin
                m_lvl[k] = !m_lvl[k];
                if (m_lvl[k]) begin
                    m_prs[k] = 1'b1;
                    pt[k]    = cyc;
                end else begin
                    m_rel[k] = 1'b1;
                end
            end
            m_rpt[k] = m_lvl[k] && rep_due(cyc - pt[k]);
        end
    endtask

    // Compare process: every edge, advance the model and check all outputs.
    initial begin
        logic [NK-1:0] kn;
        model_reset();
        forever begin
            @(posedge clk);
            kn = kif.key_n;
            if (!reset_n) model_reset();
            else          model_step(kn);
            #1;
            check("level",   kif.key_level,   m_lvl);
            check("press",   kif.key_press,   m_prs);
            check("release", kif.key_release, m_rel);
            check("repeat",  kif.key_repeat,  m_rpt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_level"},   kif.key_level,   '0);
        check({nm, "_press"},   kif.key_press,   '0);
        check({nm, "_release"}, kif.key_release, '0);
        check({nm, "_repeat"},  kif.key_repeat,  '0);
    endtask

    initial begin
        int got [3];
        int nrep, nrel, np, rise, pe, re, found;
        bit seen_rel;
        int thr;

        // Reset with both keys held, then acceptance on the 6th edge.
        reset_n   = 1'b0;
        kif.key_n = 2'b00;
        repeat (3) tick();
        check_all_zero("rst");
        reset_n = 1'b1;
        repeat (5) tick();
        check("pre_accept_level", kif.key_level, 2'b00);
        tick();
        check("accept_level",  kif.key_level,  2'b11);
        check("accept_press",  kif.key_press,  2'b11);
        check("accept_repeat", kif.key_repeat, 2'b11);

        // Auto-repeat on key 0 relative to press edge T.
        nrep = 0;
        for (int i = 0; i < 3; i++) got[i] = -1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) check("press_one_cycle", kif.key_press, 2'b00);
            if (kif.key_repeat[0]) begin
                if (nrep < 3) got[nrep] = i;
                nrep++;
            end
        end
        check_int("rep_count", nrep, 3);
        check_int("rep_t10", got[0], 10);
        check_int("rep_t13", got[1], 13);
        check_int("rep_t16", got[2], 16);

        // Release: one release strobe, no repeat afterwards.
        kif.key_n = 2'b11;
        nrel = 0; nrep = 0; seen_rel = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (kif.key_release[0]) begin nrel++; seen_rel = 1'b1; end
            else if (seen_rel && kif.key_repeat[0]) nrep++;
        end
        check_int("release_pulses", nrel, 1);
        check_int("repeat_after_release", nrep, 0);

        // Bounce on key 0: low 3, high 1, then steady low.
        rise = -1; np = 0;
        for (int e = 0; e <= 14; e++) begin
            kif.key_n = {1'b1, (e == 3)};
            tick();
            if (kif.key_level[0] && rise < 0) rise = e;
            if (kif.key_press[0]) np++;
        end
        check_int("bounce_rise_edge", rise, 9);
        check_int("bounce_press_pulses", np, 1);
        kif.key_n = 2'b11;
        repeat (10) tick();

        // Glitch on key 1: two cycles low never reaches the outputs.
        np = 0;
        for (int e = 0; e <= 11; e++) begin
            kif.key_n = {(e >= 2), 1'b1};
            tick();
            if (kif.key_level[1] || kif.key_press[1] || kif.key_repeat[1]) np++;
        end
        check_int("glitch_activity", np, 0);

        // Release accepted at T+5, inside DELAY: no repeat at T+10.
        pe = -1; re = -1; nrep = 0;
        for (int e = 0; e <= 25; e++) begin
            kif.key_n = {1'b1, !(e < 5)};
            tick();
            if (kif.key_press[0] && pe < 0) pe = e;
            if (kif.key_release[0] && re < 0) re = e;
            if (kif.key_repeat[0]) nrep++;
        end
        check_int("delay_press_edge", pe, 5);
        check_int("delay_release_edge", re, 10);
        check_int("delay_repeat_count", nrep, 1);

        // Re-press: fresh sequence, then reset at T+14 while in RATE.
        nrep = 0;
        for (int i = 0; i < 3; i++) got[i] = -1;
        kif.key_n = 2'b10;
        for (int e = 0; e <= 18; e++) begin
            tick();
            if (kif.key_repeat[0]) begin
                if (nrep < 3) got[nrep] = e;
                nrep++;
            end
        end
        check_int("repress_rep0", got[0], 5);
        check_int("repress_rep1", got[1], 15);
        check_int("repress_rep2", got[2], 18);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_rate_rst");
        repeat (2) tick();
        reset_n = 1'b1;
        found = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (kif.key_press[0] && found < 0) found = i;
        end
        check_int("post_reset_press_edge", found, 6);
        kif.key_n = 2'b11;
        repeat (12) tick();

        // Random phase: alternating bouncy and steady segments, rare resets.
        for (int c = 0; c < 4000; c++) begin
            thr = ((c / 500) % 2 == 0) ? 40 : 3;
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 99) < thr) kif.key_n[k] = ~kif.key_n[k];
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0;
                tick();
                reset_n = ($urandom_range(0, 1) == 0);
            end else begin
                reset_n = 1'b1;
                tick();
            end
        end
        reset_n = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions raw active-low push-button inputs from the board: synchronise, debounce, invert to active-high.
- key_level drives the in_port of the keys PIO input slave.
- Also emits one-cycle press/release strobes and a typematic auto-repeat strobe, used by game logic for held movement keys.
- All keys are handled independently by identical per-key logic.

Parameters:
NUM_KEYS, 2, number of keys handled (width of all key vectors)
CNT_W, 24, width of the debounce and repeat counters; every timing parameter must be less than 2**CNT_W
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required to accept a level change (10 ms at 50 MHz); must be at least 1
REPEAT_DELAY, 15000000, cycles from press strobe to first auto-repeat strobe (300 ms); must be at least 1
REPEAT_RATE, 5000000, cycles between subsequent auto-repeat strobes (100 ms); must be at least 1

Ports:
clk  input  1  system clock
reset_n  input  1  reset
key_n  input  NUM_KEYS  raw asynchronous buttons, 0 = pressed
key_level  output  NUM_KEYS  debounced state, 1 = pressed; feeds PIO in_port
key_press  output  NUM_KEYS  one-cycle strobe on accepted press
key_release  output  NUM_KEYS  one-cycle strobe on accepted release
key_repeat  output  NUM_KEYS  one-cycle strobe on press and on each auto-repeat tick

Behaviour:
- Clock and reset: clock clk; reset reset_n, asynchronous, active-low.
- Reset values:
  - Synchroniser flops = 1 (released).
  - All counters = 0; repeat FSM = IDLE.
  - key_level, key_press, key_release, key_repeat = 0.
  - Reset mid-press or mid-repeat aborts immediately. No strobe is emitted on reset release, even if a key is held. A held key is re-accepted after the normal debounce latency.
- Synchroniser: two flops per key. raw_s = NOT sync2.
- Debounce, per key, each clk edge:
  - if raw_s == key_level: dcnt <= 0
  - else if dcnt == DEBOUNCE_CYCLES-1: key_level <= raw_s, dcnt <= 0
  - else: dcnt <= dcnt+1
- Debounce latency:
  - key_level changes on rising edge E+DEBOUNCE_CYCLES+1, where E is the first edge sampling the new key_n value.
  - Any bounce returning raw_s to key_level before that restarts the count from 0.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never reaches key_level.
- Strobes are registered and coincide with the first cycle of the new key_level value:
  - key_press: key_level 0->1.
  - key_release: key_level 1->0.
  - Never both in the same cycle for one key.
- Repeat FSM, per key, states IDLE, DELAY, RATE; counter rcnt:
  - IDLE: on accepted press, key_repeat = 1 (same cycle as key_press), rcnt <= 0, go DELAY.
  - DELAY: while key_level = 1, rcnt++. When rcnt == REPEAT_DELAY-1: pulse key_repeat, rcnt <= 0, go RATE.
  - RATE: while key_level = 1, rcnt++. When rcnt == REPEAT_RATE-1: pulse key_repeat, rcnt <= 0, stay in RATE.
  - Accepted release in DELAY or RATE: go IDLE, rcnt <= 0, no repeat strobe that cycle.
- Repeat timing: with press strobe at cycle T, repeat strobes occur at T, T+REPEAT_DELAY, T+REPEAT_DELAY+REPEAT_RATE, and every REPEAT_RATE after, while held.
- Counters never wrap: each is cleared on its terminal count.
- Keys are fully independent. Simultaneous press, release or repeat events on different keys all strobe in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, NUM_KEYS=2):
- Reset: hold reset_n=0 with key_n=2'b00 -> all outputs 0. After release, key_level=2'b11 at the 6th edge; key_press and key_repeat = 2'b11 for exactly that one cycle.
- Bounce: key_n[0] low for 3 cycles, high for 1, low steady -> no change during the bounce. key_level[0] rises 6 edges after the final low sample; exactly one key_press[0] pulse.
- Glitch: key_n[1] low for 2 cycles only -> key_level, key_press and key_repeat on key 1 stay 0 throughout.
- Auto-repeat: hold key 0 pressed, press strobe at cycle T -> key_repeat[0] at T, T+10, T+13, T+16. Release -> key_release[0] one pulse, no further repeat strobes.
- Release during DELAY at T+5 (accepted) -> no repeat at T+10. Re-press -> fresh sequence starting at the new press.
- Reset mid-RATE: assert reset_n=0 at T+14 -> outputs 0 immediately, FSM IDLE. Key still held after reset release -> new press strobe after 6 edges.
